approx_mul_rr_scheduler: RTL

Sequencer and arbiter that shares one combinational approximate multiplier instance (2 x OPW-bit operands in, RESW-bit product out) among NREQ requesters. It selects requesters round-robin, drives the shared multiplier for one settle cycle, and returns the tagged product through a valid/ready response channel. In parallel, it checks every product against the exact product and keeps error statistics against threshold ET, so approximate variants can be screened in-system.

---
 rtl/approx_mul_rr_scheduler.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/approx_mul_rr_scheduler.sv
// Round-robin sequencer that time-shares one combinational approximate multiplier
// and screens every product against the exact result, keeping error statistics.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | scanning requesters from the rr pointer; grant and latch
// S_ISSUE | operands on the shared multiplier; capture product and error
// S_HOLD  | response valid, waiting for the consumer to accept
module approx_mul_rr_scheduler #(
  parameter int NREQ = 4,
  parameter int OPW  = 2,
  parameter int RESW = 4,
  parameter int ET   = 0,
  parameter int CNTW = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NREQ-1:0]          i_req_valid,
  input  logic [NREQ*OPW-1:0]      i_req_a,
  input  logic [NREQ*OPW-1:0]      i_req_b,
  output logic [NREQ-1:0]          o_req_ready,
  output logic [2*OPW-1:0]         o_mul_in,
  input  logic [RESW-1:0]          i_mul_out,
  output logic                     o_rsp_valid,
  input  logic                     i_rsp_ready,
  output logic [RESW-1:0]          o_rsp_data,
  output logic [$clog2(NREQ)-1:0]  o_rsp_id,
  output logic [RESW-1:0]          o_rsp_err,
  input  logic                     i_stats_clr,
  output logic [CNTW-1:0]          o_viol_count,
  output logic [RESW-1:0]          o_max_err,
  output logic                     o_viol_sticky
);

  localparam int IDW = $clog2(NREQ);
  localparam logic [RESW-1:0] ET_V = RESW'(ET);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_HOLD} state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [IDW-1:0]  r_rr;
  logic [IDW-1:0]  r_id;
  logic [OPW-1:0]  r_a;
  logic [OPW-1:0]  r_b;
  logic            r_valid;
  logic [RESW-1:0] r_data;
  logic [RESW-1:0] r_err;
  logic [CNTW-1:0] r_viol_count;
  logic [RESW-1:0] r_max_err;
  logic            r_viol_sticky;

  logic            w_found;
  logic [IDW-1:0]  w_gnt;
  logic [IDW-1:0]  w_rr_nxt;
  logic [RESW-1:0] w_a_ext;
  logic [RESW-1:0] w_b_ext;
  logic [RESW-1:0] w_exact;
  logic [RESW-1:0] w_err;
  logic            w_viol;

  // First valid requester at or after the rr pointer, wrapping modulo NREQ.
  always_comb begin
    int v_idx;
    w_found = 1'b0;
    w_gnt   = '0;
    v_idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      v_idx = int'(r_rr) + k;
      if (v_idx >= NREQ) v_idx = v_idx - NREQ;
      if (!w_found && i_req_valid[v_idx]) begin
        w_found = 1'b1;
        w_gnt   = IDW'(v_idx);
      end
    end
  end

  assign w_rr_nxt = (w_gnt == IDW'(NREQ - 1)) ? '0 : w_gnt + 1'b1;

  assign o_req_ready = (!i_rst && r_state == S_IDLE && w_found) ?
                       (NREQ'(1) << w_gnt) : '0;

  assign w_a_ext = RESW'(r_a);
  assign w_b_ext = RESW'(r_b);
  assign w_exact = w_a_ext * w_b_ext;
  assign w_err   = (i_mul_out >= w_exact) ? (i_mul_out - w_exact) : (w_exact - i_mul_out);
  assign w_viol  = (w_err > ET_V);

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = S_HOLD;
      S_HOLD:  if (i_rsp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rr    <= '0;
      r_id    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_err   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_a  <= i_req_a[w_gnt*OPW +: OPW];
            r_b  <= i_req_b[w_gnt*OPW +: OPW];
            r_id <= w_gnt;
            r_rr <= w_rr_nxt;
          end
        end
        S_ISSUE: begin
          r_data  <= i_mul_out;
          r_err   <= w_err;
          r_valid <= 1'b1;
        end
        S_HOLD: begin
          if (i_rsp_ready) r_valid <= 1'b0;
        end
        default: r_valid <= 1'b0;
      endcase
    end
  end

  // Clear wins over a same-cycle sample; that sample's response still goes out.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_stats_clr) begin
      r_viol_count  <= '0;
      r_max_err     <= '0;
      r_viol_sticky <= 1'b0;
    end else if (r_state == S_ISSUE) begin
      if (w_viol) begin
        if (r_viol_count != {CNTW{1'b1}}) r_viol_count <= r_viol_count + 1'b1;
        r_viol_sticky <= 1'b1;
      end
      if (w_err > r_max_err) r_max_err <= w_err;
    end
  end

  assign o_mul_in      = {r_b, r_a};
  assign o_rsp_valid   = r_valid;
  assign o_rsp_data    = r_data;
  assign o_rsp_id      = r_id;
  assign o_rsp_err     = r_err;
  assign o_viol_count  = r_viol_count;
  assign o_max_err     = r_max_err;
  assign o_viol_sticky = r_viol_sticky;

endmodule
